// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter: op codes, FSM state encoding
// and the op-code validity check.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both requesters of alu_arbiter.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND: result = x & y;
      OP_OR:  result = x | y;
      OP_ADD: result = x + y;
      OP_SUB: result = x - y;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_NOR: result = ~(x | y);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; round-robin grant, one transaction in flight,
// FSM IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [1:0]       fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the matching valid's consumer side.
  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             grant_q;
  logic             accept;
  logic             rsp_fire;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] exec_result;
  logic             exec_err;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .x      (x_q),
    .y      (y_q),
    .result (alu_result)
  );

  // A tie goes to the port that did not win last; a lone valid port always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == ST_IDLE) && !reset && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && !reset && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state == ST_RESP) && !reset && !grant_q;
  assign rsp1_valid = (state == ST_RESP) && !reset && grant_q;
  assign rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign exec_err    = !op_supported(op_q);
  assign exec_result = exec_err ? '0 : alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_q    <= grant;
            last_grant <= grant;
            op_q       <= grant ? req1_op : req0_op;
            x_q        <= grant ? req1_x  : req0_x;
            y_q        <= grant ? req1_y  : req0_y;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= exec_result;
          zero_q   <= (exec_result == '0);
          err_q    <= exec_err;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_result = result_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_err    = err_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [1:0]   fsm_state;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {err, result} straight from the op-code table.
  function automatic logic [W:0] model_alu(input logic [3:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [W-1:0] r;
    logic e;
    e = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b1100: r = ~(x | y);
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  bit           busy = 0;
  int           age = 0;
  bit           owner = 0;
  bit           last = 1;
  bit           after_rst = 0;
  bit           fire0 = 0, fire1 = 0;
  logic [W-1:0] exp_res;
  logic         exp_err;
  logic [W:0]   m;

  // One compare process: every cycle, readies and responses against the model.
  always @(negedge clk) begin
    logic er0, er1, ev;
    fire0 = 0;
    fire1 = 0;
    if (reset) begin
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      chk("reset_rsp0_valid", rsp0_valid, 0);
      chk("reset_rsp1_valid", rsp1_valid, 0);
      busy = 0;
      last = 1;
      after_rst = 1;
    end else begin
      if (after_rst) begin
        chk("post_reset_result", rsp0_result, 0);
        chk("post_reset_zero", rsp0_zero, 0);
        chk("post_reset_err", rsp1_err, 0);
        after_rst = 0;
      end
      if (busy) age++;
      er0 = !busy && req0_valid && (!req1_valid || last == 1);
      er1 = !busy && req1_valid && (!req0_valid || last == 0);
      chk("ready0", req0_ready, er0);
      chk("ready1", req1_ready, er1);
      ev = busy && age >= 2;
      chk("rsp0_valid", rsp0_valid, ev && owner == 0);
      chk("rsp1_valid", rsp1_valid, ev && owner == 1);
      if (ev) begin
        chk("rsp_result", owner ? rsp1_result : rsp0_result, exp_res);
        chk("rsp_zero", owner ? rsp1_zero : rsp0_zero, exp_res == 0);
        chk("rsp_err", owner ? rsp1_err : rsp0_err, exp_err);
        if (owner ? rsp1_ready : rsp0_ready) busy = 0;
      end else if (er0 || er1) begin
        busy = 1;
        age = 0;
        owner = er1;
        last = er1;
        m = er1 ? model_alu(req1_op, req1_x, req1_y) : model_alu(req0_op, req0_x, req0_y);
        exp_res = m[W-1:0];
        exp_err = m[W];
      end
      fire0 = req0_valid & req0_ready;
      fire1 = req1_valid & req1_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (p == 0) begin req0_valid = 1; req0_op = op; req0_x = x; req0_y = y; end
    else        begin req1_valid = 1; req1_op = op; req1_x = x; req1_y = y; end
  endtask

  task automatic wait_accept(input int p, output int t);
    t = -1;
    for (int k = 0; k < 20 && t < 0; k++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) t = cyc;
    end
    if (t < 0) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_rsp(input int p, input int hold, output int t, output logic [W-1:0] r,
                          output logic z, output logic e);
    t = -1; r = '0; z = 0; e = 0;
    if (p == 0) rsp0_ready = (hold == 0); else rsp1_ready = (hold == 0);
    for (int k = 0; k < 20 && t < 0; k++) begin
      @(negedge clk);
      if ((p == 0) ? rsp0_valid : rsp1_valid) begin
        t = cyc;
        r = (p == 0) ? rsp0_result : rsp1_result;
        z = (p == 0) ? rsp0_zero : rsp1_zero;
        e = (p == 0) ? rsp0_err : rsp1_err;
      end
    end
    if (t < 0) chk("rsp_timeout", 1, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_result_stable", (p == 0) ? rsp0_result : rsp1_result, r);
      chk("hold_no_accept", req0_ready | req1_ready, 0);
    end
    if (p == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int p, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string name, input logic [W-1:0] er, input logic ez, input logic ee);
    int ta, tr;
    logic [W-1:0] r;
    logic z, e;
    drive(p, op, x, y);
    wait_accept(p, ta);
    wait_rsp(p, 0, tr, r, z, e);
    chk({name, "_latency"}, tr - ta, 2);
    chk({name, "_result"}, r, er);
    chk({name, "_zero"}, z, ez);
    chk({name, "_err"}, e, ee);
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] tbl [6];
    tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
    return $urandom;
  endfunction

  bit rand_on = 0;
  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      reset = ($urandom_range(0, 149) == 0);
      if (!req0_valid || fire0) begin
        if ($urandom_range(0, 1) == 1) drive(0, rand_op(), rand_opnd(), rand_opnd());
        else req0_valid = 0;
      end else if ($urandom_range(0, 9) == 0) req0_valid = 0;
      if (!req1_valid || fire1) begin
        if ($urandom_range(0, 1) == 1) drive(1, rand_op(), rand_opnd(), rand_opnd());
        else req1_valid = 0;
      end else if ($urandom_range(0, 9) == 0) req1_valid = 0;
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int ta, tr, tc;
    logic [W-1:0] r;
    logic z, e;
    logic [W:0] pin;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    pin = model_alu(4'b0010, 2565, 1560);  chk("model_add", pin, 33'd4125);
    pin = model_alu(4'b0110, 2565, 3560);  chk("model_sub_wrap", pin, 33'h0_FFFFFC1D);
    pin = model_alu(4'b1111, 7, 9);        chk("model_bad_op", pin, 33'h1_00000000);

    run_op(0, 4'b0010, 2565, 1560, "add_port0", 4125, 0, 0);

    // Fresh reset so the first tie starts from last_grant = 1.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    drive(0, 4'b0110, 2565, 1560);
    drive(1, 4'b0001, 2565, 1560);
    wait_accept(0, ta);
    wait_rsp(0, 0, tr, r, z, e);
    chk("tie1_port0_result", r, 1005);
    tc = cyc;
    drive(0, 4'b0000, 32'hFF, 32'h0F);
    wait_accept(1, ta);
    chk("tie2_port1_first", ta, tc);
    wait_rsp(1, 0, tr, r, z, e);
    chk("tie_port1_result", r, 32'h00000E1D);
    wait_accept(0, ta);
    wait_rsp(0, 0, tr, r, z, e);
    chk("tie_port0_and", r, 32'h0F);

    drive(1, 4'b0110, 2565, 3560);
    wait_accept(1, ta);
    drive(0, 4'b0010, 1, 1);
    wait_rsp(1, 4, tr, r, z, e);
    chk("backpressure_result", r, 32'hFFFFFC1D);
    wait_accept(0, ta);
    chk("backpressure_next_accept", ta, tr + 5);
    wait_rsp(0, 0, tr, r, z, e);
    chk("backpressure_port0", r, 2);

    run_op(0, 4'b1111, 123, 456, "bad_op", 0, 1, 1);
    run_op(0, 4'b0110, 5, 5, "sub_zero", 0, 1, 0);
    run_op(0, 4'b0111, 2565, 1560, "slt_false", 0, 1, 0);
    run_op(1, 4'b0111, 32'hFFFFFFFF, 1, "slt_signed", 1, 0, 0);
    run_op(1, 4'b1100, 0, 0, "nor", 32'hFFFFFFFF, 0, 0);

    drive(0, 4'b0010, 7, 8);
    wait_accept(0, ta);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("reset_drop_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    @(posedge clk); #1;
    run_op(0, 4'b0010, 2565, 1560, "after_drop", 4125, 0, 0);

    rand_on = 1;
    repeat (3000) @(posedge clk);
    rand_on = 0;
    #2;
    reset = 0;
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
